draw_dog: RTL and testbench

- Pixel-pipeline stage directly downstream of the dog movement/animation controller.
- Consumes dog_xpos, dog_ypos and photo_index, and overlays the selected dog sprite frame onto the incoming VGA timing/RGB stream.
- Addresses an external synchronous sprite ROM holding all animation frames.
- Latches sprite position and frame once per frame so the dog never tears mid-frame.

---
 rtl/draw_dog.sv | 119 +++++++++++
 tb/tb_draw_dog.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/draw_dog.sv
// Overlays an animated dog sprite from an external synchronous ROM onto the VGA stream.
// Position and frame are sampled once per frame on the rising edge of vblnk, so the sprite never tears.
module draw_dog #(
    parameter int          SPR_W      = 64,
    parameter int          SPR_H      = 64,
    parameter int          NUM_FRAMES = 9,
    parameter int          ADDR_W     = 16,
    parameter logic [11:0] KEY_RGB    = 12'hF0F
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [10:0]       hcount_in,
    input  logic [10:0]       vcount_in,
    input  logic              hsync_in,
    input  logic              vsync_in,
    input  logic              hblnk_in,
    input  logic              vblnk_in,
    input  logic [11:0]       rgb_in,
    input  logic [11:0]       dog_xpos,
    input  logic [11:0]       dog_ypos,
    input  logic [3:0]        photo_index,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [11:0]       rom_data,
    output logic [10:0]       hcount_out,
    output logic [10:0]       vcount_out,
    output logic              hsync_out,
    output logic              vsync_out,
    output logic              hblnk_out,
    output logic              vblnk_out,
    output logic [11:0]       rgb_out
);
    localparam int          COL_W  = $clog2(SPR_W);
    localparam int          ROW_W  = $clog2(SPR_H);
    localparam int          TW     = 11 + 11 + 4 + 12;
    localparam logic [11:0] PARK_X = 12'd1024;
    localparam logic [11:0] PARK_Y = 12'd515;

    logic              r_vblnk_prev;
    logic [11:0]       r_shadow_x;
    logic [11:0]       r_shadow_y;
    logic [3:0]        r_shadow_frame;

    logic [12:0]       w_h13;
    logic [12:0]       w_v13;
    logic [12:0]       w_x13;
    logic [12:0]       w_y13;
    logic              w_in_box;
    logic [COL_W-1:0]  w_col;
    logic [ROW_W-1:0]  w_row;
    logic [ADDR_W-1:0] w_addr;

    logic [TW-1:0]     w_pipe_in;
    logic [TW-1:0]     r_pipe_d1;
    logic [TW-1:0]     r_pipe_d2;
    logic              r_in_box_d1;
    logic              r_in_box_d2;
    logic [ADDR_W-1:0] r_rom_addr;
    logic [11:0]       w_rgb_d2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vblnk_prev   <= 1'b0;
            r_shadow_x     <= PARK_X;
            r_shadow_y     <= PARK_Y;
            r_shadow_frame <= 4'd0;
        end else begin
            r_vblnk_prev <= vblnk_in;
            if (vblnk_in && !r_vblnk_prev) begin
                r_shadow_x     <= dog_xpos;
                r_shadow_y     <= dog_ypos;
                r_shadow_frame <= photo_index;
            end
        end
    end

    // 13-bit compares keep x/y near 4095 from wrapping the box onto column/row 0.
    assign w_h13 = {2'b00, hcount_in};
    assign w_v13 = {2'b00, vcount_in};
    assign w_x13 = {1'b0, r_shadow_x};
    assign w_y13 = {1'b0, r_shadow_y};

    assign w_in_box = (w_h13 >= w_x13) && (w_h13 < w_x13 + 13'(SPR_W)) &&
                      (w_v13 >= w_y13) && (w_v13 < w_y13 + 13'(SPR_H)) &&
                      (32'(r_shadow_frame) < 32'(NUM_FRAMES)) &&
                      !hblnk_in && !vblnk_in;

    assign w_col  = COL_W'(w_h13 - w_x13);
    assign w_row  = ROW_W'(w_v13 - w_y13);
    assign w_addr = ADDR_W'(32'(r_shadow_frame) * 32'(SPR_W * SPR_H) +
                            32'(w_row) * 32'(SPR_W) + 32'(w_col));

    assign w_pipe_in = {hcount_in, vcount_in, hsync_in, vsync_in, hblnk_in, vblnk_in, rgb_in};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pipe_d1   <= '0;
            r_pipe_d2   <= '0;
            r_in_box_d1 <= 1'b0;
            r_in_box_d2 <= 1'b0;
            r_rom_addr  <= '0;
        end else begin
            r_pipe_d1   <= w_pipe_in;
            r_pipe_d2   <= r_pipe_d1;
            r_in_box_d1 <= w_in_box;
            r_in_box_d2 <= r_in_box_d1;
            if (w_in_box) begin
                r_rom_addr <= w_addr;
            end
        end
    end

    assign rom_addr = r_rom_addr;
    assign {hcount_out, vcount_out, hsync_out, vsync_out, hblnk_out, vblnk_out, w_rgb_d2} = r_pipe_d2;

    // rom_data is the ROM's registered read of the address issued one cycle earlier,
    // so it lines up with the second-stage registers here.
    assign rgb_out = (r_in_box_d2 && (rom_data != KEY_RGB)) ? rom_data : w_rgb_d2;

endmodule

// File: tb/tb_draw_dog.sv
// Scoreboard bench for draw_dog: a per-pixel model queues the expected output bundle,
// which is popped two clocks later when the pipeline delivers that pixel.
module tb_draw_dog;
    localparam logic [11:0] KEY = 12'hF0F;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [10:0] hcount_in = '0;
    logic [10:0] vcount_in = '0;
    logic        hsync_in = 1'b0;
    logic        vsync_in = 1'b0;
    logic        hblnk_in = 1'b0;
    logic        vblnk_in = 1'b0;
    logic [11:0] rgb_in = '0;
    logic [11:0] dog_xpos = '0;
    logic [11:0] dog_ypos = '0;
    logic [3:0]  photo_index = '0;
    logic [15:0] rom_addr;
    logic [11:0] rom_data = '0;
    logic [10:0] hcount_out;
    logic [10:0] vcount_out;
    logic        hsync_out;
    logic        vsync_out;
    logic        hblnk_out;
    logic        vblnk_out;
    logic [11:0] rgb_out;
    logic [37:0] act;

    int n_cmp = 0;
    int n_err = 0;
    int rom_mode = 0;

    int          m_sx, m_sy, m_sf;
    logic        m_vprev;
    logic [15:0] m_addr;
    logic [37:0] sb[$];

    draw_dog dut (
        .clk(clk), .rst_n(rst_n),
        .hcount_in(hcount_in), .vcount_in(vcount_in),
        .hsync_in(hsync_in), .vsync_in(vsync_in),
        .hblnk_in(hblnk_in), .vblnk_in(vblnk_in),
        .rgb_in(rgb_in),
        .dog_xpos(dog_xpos), .dog_ypos(dog_ypos), .photo_index(photo_index),
        .rom_addr(rom_addr), .rom_data(rom_data),
        .hcount_out(hcount_out), .vcount_out(vcount_out),
        .hsync_out(hsync_out), .vsync_out(vsync_out),
        .hblnk_out(hblnk_out), .vblnk_out(vblnk_out),
        .rgb_out(rgb_out)
    );

    always #5 clk = ~clk;

    assign act = {hcount_out, vcount_out, hsync_out, vsync_out, hblnk_out, vblnk_out, rgb_out};

    function automatic logic [11:0] romf(input logic [15:0] a, input int mode);
        logic [11:0] v;
        case (mode)
            0:       v = 12'h0A5;
            1:       v = KEY;
            default: v = a[11:0] ^ {8'h00, a[15:12]};
        endcase
        return v;
    endfunction

    always @(posedge clk) rom_data <= romf(rom_addr, rom_mode);

    task automatic model_reset();
        m_sx = 1024; m_sy = 515; m_sf = 0; m_vprev = 1'b0; m_addr = '0;
        sb.delete();
    endtask

    // Drives one pixel, queues its expected output bundle, advances one clock.
    task automatic drive_pixel(input int h, input int v, input logic hs, input logic vs,
                               input logic hb, input logic vb, input logic [11:0] rgb);
        bit          inb;
        logic [11:0] r;
        logic [11:0] rd;
        hcount_in = h[10:0]; vcount_in = v[10:0];
        hsync_in = hs; vsync_in = vs; hblnk_in = hb; vblnk_in = vb; rgb_in = rgb;
        inb = (h >= m_sx) && (h < m_sx + 64) && (v >= m_sy) && (v < m_sy + 64) &&
              (m_sf < 9) && !hb && !vb;
        if (inb) m_addr = 16'(m_sf * 4096 + (v - m_sy) * 64 + (h - m_sx));
        rd = romf(m_addr, rom_mode);
        r  = (inb && rd != KEY) ? rd : rgb;
        sb.push_back({h[10:0], v[10:0], hs, vs, hb, vb, r});
        if (vb && !m_vprev) begin
            m_sx = int'(dog_xpos); m_sy = int'(dog_ypos); m_sf = int'(photo_index);
        end
        m_vprev = vb;
        @(posedge clk);
        #1;
    endtask

    // Produces a vblnk rising edge with the given controller values; its pixels are not scored.
    task automatic new_frame(input int x, input int y, input int idx);
        dog_xpos = 12'(x); dog_ypos = 12'(y); photo_index = 4'(idx);
        drive_pixel(0, 770, 0, 0, 1, 0, 12'h000);
        if (sb.size() == 2) sb.delete(0);
        for (int i = 0; i < 3; i++) begin
            drive_pixel(0, 771, 0, 1, 1, 1, 12'h000);
            if (sb.size() == 2) sb.delete(0);
        end
        drive_pixel(0, 0, 0, 0, 1, 0, 12'h000);
        if (sb.size() == 2) sb.delete(0);
    endtask

    task automatic test_reset();
        logic [37:0] e;
        #1;
        n_cmp++;
        if (act !== '0) begin n_err++; $display("FAIL reset_outputs got=%h exp=0", act); end
        n_cmp++;
        if (rom_addr !== '0) begin n_err++; $display("FAIL reset_rom_addr got=%h exp=0", rom_addr); end
        @(posedge clk); #1;
        rst_n = 1'b1;
        model_reset();
        for (int i = 0; i < 20; i++) begin
            drive_pixel(100 + i, 20, i[0], 1'b0, 1'b0, 1'b0, 12'($urandom));
            if (sb.size() == 2) begin
                e = sb.pop_front(); n_cmp++;
                if (act !== e) begin n_err++; $display("FAIL reset_release i=%0d got=%h exp=%h", i, act, e); end
            end
        end
        #2 rst_n = 1'b0;
        #1;
        n_cmp++;
        if (act !== '0) begin n_err++; $display("FAIL reset_async got=%h exp=0", act); end
        @(posedge clk); #1;
        rst_n = 1'b1;
        model_reset();
        for (int i = 0; i < 10; i++) begin
            drive_pixel(500 + i, 600, 1'b0, 1'b1, 1'b0, 1'b0, 12'($urandom));
            if (sb.size() == 2) begin
                e = sb.pop_front(); n_cmp++;
                if (act !== e) begin n_err++; $display("FAIL reset_after i=%0d got=%h exp=%h", i, act, e); end
            end
        end
    endtask

    task automatic test_frame_latch();
        logic [37:0] e;
        int rows[3] = '{400, 463, 464};
        rom_mode = 2;
        dog_xpos = 12'd300; dog_ypos = 12'd400; photo_index = 4'd2;
        for (int h = 296; h <= 306; h++) begin
            drive_pixel(h, 400, 0, 0, 0, 0, 12'($urandom));
            if (sb.size() == 2) begin
                e = sb.pop_front(); n_cmp++;
                if (act !== e) begin n_err++; $display("FAIL latch_midframe h=%0d got=%h exp=%h", h, act, e); end
            end
        end
        new_frame(300, 400, 2);
        dog_xpos = 12'd500; dog_ypos = 12'd10; photo_index = 4'd5;
        foreach (rows[r]) begin
            for (int h = 296; h <= 368; h++) begin
                drive_pixel(h, rows[r], 0, 0, 0, 0, 12'($urandom));
                if (h == 300 && rows[r] == 400) begin
                    n_cmp++;
                    if (rom_addr !== 16'd8192) begin n_err++; $display("FAIL addr_first got=%0d exp=8192", rom_addr); end
                end
                if (h == 363 && rows[r] == 463) begin
                    n_cmp++;
                    if (rom_addr !== 16'd12287) begin n_err++; $display("FAIL addr_last got=%0d exp=12287", rom_addr); end
                end
                n_cmp++;
                if (rom_addr !== m_addr) begin n_err++; $display("FAIL addr_track h=%0d v=%0d got=%0d exp=%0d", h, rows[r], rom_addr, m_addr); end
                if (sb.size() == 2) begin
                    e = sb.pop_front(); n_cmp++;
                    if (act !== e) begin n_err++; $display("FAIL latch_draw h=%0d v=%0d got=%h exp=%h", h, rows[r], act, e); end
                end
            end
        end
    endtask

    task automatic test_compositing();
        logic [37:0] e;
        int hits;
        rom_mode = 0;
        new_frame(300, 400, 2);
        for (int m = 0; m < 2; m++) begin
            hits = 0;
            rom_mode = (m == 0) ? 0 : 1;
            for (int h = 296; h <= 369; h++) begin
                drive_pixel(h, 410 + m * 10, 0, 0, 0, 0, 12'h333);
                if (sb.size() == 2) begin
                    e = sb.pop_front(); n_cmp++;
                    if (rgb_out == 12'h0A5) hits++;
                    if (act !== e) begin n_err++; $display("FAIL composite mode=%0d h=%0d got=%h exp=%h", m, h, act, e); end
                end
            end
            n_cmp++;
            if (hits != ((m == 0) ? 64 : 0)) begin
                n_err++; $display("FAIL composite_count mode=%0d got=%0d exp=%0d", m, hits, (m == 0) ? 64 : 0);
            end
        end
    endtask

    task automatic test_boundary();
        logic [37:0] e;
        int hits;
        rom_mode = 0;
        new_frame(1000, 100, 0);
        hits = 0;
        for (int h = 990; h <= 1040; h++) begin
            drive_pixel(h, 120, 0, 0, h >= 1024, 0, 12'h333);
            if (sb.size() == 2) begin
                e = sb.pop_front(); n_cmp++;
                if (rgb_out == 12'h0A5) hits++;
                if (act !== e) begin n_err++; $display("FAIL edge_right h=%0d got=%h exp=%h", h, act, e); end
            end
        end
        n_cmp++;
        if (hits != 24) begin n_err++; $display("FAIL edge_right_count got=%0d exp=24", hits); end
        new_frame(4090, 100, 0);
        hits = 0;
        for (int r = 0; r < 2; r++) begin
            for (int h = 0; h <= 60; h++) begin
                drive_pixel(h, 100 + r * 20, 0, 0, 0, 0, 12'h333);
                if (sb.size() == 2) begin
                    e = sb.pop_front(); n_cmp++;
                    if (rgb_out == 12'h0A5) hits++;
                    if (act !== e) begin n_err++; $display("FAIL edge_wrap h=%0d got=%h exp=%h", h, act, e); end
                end
            end
        end
        n_cmp++;
        if (hits != 0) begin n_err++; $display("FAIL edge_wrap_count got=%0d exp=0", hits); end
    endtask

    task automatic test_invalid_frame();
        logic [37:0] e;
        int hits;
        rom_mode = 0;
        new_frame(300, 400, 9);
        hits = 0;
        for (int h = 296; h <= 368; h++) begin
            drive_pixel(h, 410, 0, 0, 0, 0, 12'h333);
            if (sb.size() == 2) begin
                e = sb.pop_front(); n_cmp++;
                if (rgb_out == 12'h0A5) hits++;
                if (act !== e) begin n_err++; $display("FAIL invalid_frame h=%0d got=%h exp=%h", h, act, e); end
            end
        end
        n_cmp++;
        if (hits != 0) begin n_err++; $display("FAIL invalid_frame_count got=%0d exp=0", hits); end
    endtask

    task automatic test_alignment();
        logic [37:0] e;
        rom_mode = 2;
        for (int i = 0; i < 300; i++) begin
            dog_xpos = 12'($urandom_range(0, 1100));
            dog_ypos = 12'($urandom_range(0, 800));
            photo_index = 4'($urandom_range(0, 10));
            drive_pixel($urandom_range(0, 1100), $urandom_range(0, 800), 1'($urandom), 1'($urandom),
                        ($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0), 12'($urandom));
            if (sb.size() == 2) begin
                e = sb.pop_front(); n_cmp++;
                if (act !== e) begin n_err++; $display("FAIL align i=%0d got=%h exp=%h", i, act, e); end
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_frame_latch();
        test_compositing();
        test_boundary();
        test_invalid_frame();
        test_alignment();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule
